// File: rtl/pio_irq_master.sv
// Purpose: services a PIO slave's level interrupt: mask it, read the data port, hand the value out, poll until clear, unmask.
// Latency: irq sampled at edge k -> mask-off write committed at k+1, evt_valid first sampled high at edge k+4.
// Backpressure: evt_valid/evt_ready handshake; the FSM waits in PUSH with evt_data held for as long as evt_ready stays low.
//
// Ports:
//   clk, reset_n            single clock, asynchronous active-low reset
//   en                      service enable, gates only the start of a new service
//   irq                     level interrupt from the PIO slave
//   address/chipselect/
//   write_n/writedata/
//   readdata                slave bus master side; reads return data one cycle later, no waitrequest
//   evt_valid/evt_ready/
//   evt_data                captured data-port value, one event per service
//   evt_count               count of accepted events, wraps to zero
//
// Optional build: define PIO_IRQ_MASTER_ACK_EN to pulse out_port (address 0) to 1 then 0
// after each accepted event; without it address 0 is only ever read.

module pio_irq_master #(
    parameter int DATA_W = 1,   // captured data width, 1..32
    parameter int CNT_W  = 16   // serviced-event counter width
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              irq,
    output logic [1:0]        address,
    output logic              chipselect,
    output logic              write_n,
    output logic [31:0]       writedata,
    input  logic [31:0]       readdata,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [DATA_W-1:0] evt_data,
    output logic [CNT_W-1:0]  evt_count
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_MASK_OFF,
        ST_RD_ADDR,
        ST_RD_WAIT,
        ST_PUSH,
        ST_POLL_ADDR,
        ST_POLL_WAIT,
`ifdef PIO_IRQ_MASTER_ACK_EN
        ST_UNMASK,
        ST_ACK_SET,
        ST_ACK_CLR
`else
        ST_UNMASK
`endif
    } state_t;

    state_t state;
    state_t state_nxt;

    // Bus values decoded purely from the state register.
    logic [1:0]  bus_addr;
    logic        bus_cs;
    logic        bus_wn;
    logic [31:0] bus_wd;

    logic handshake;
    logic poll_clear;

    // Only the low DATA_W bits of readdata carry port data.
    logic unused_rd;
    assign unused_rd = &{1'b0, readdata};

    assign handshake  = evt_valid & evt_ready;
    assign poll_clear = (readdata[DATA_W-1:0] == '0);

    //--------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    //--------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:      state_nxt = ST_IDLE;
            // en only gates entry; once a service starts it always completes.
            ST_IDLE:      if (irq && en) state_nxt = ST_MASK_OFF;
            ST_MASK_OFF:  state_nxt = ST_RD_ADDR;
            ST_RD_ADDR:   state_nxt = ST_RD_WAIT;
            ST_RD_WAIT:   state_nxt = ST_PUSH;
            ST_PUSH: begin
                if (evt_ready) begin
`ifdef PIO_IRQ_MASTER_ACK_EN
                    state_nxt = ST_ACK_SET;
`else
                    state_nxt = ST_POLL_ADDR;
`endif
                end
            end
`ifdef PIO_IRQ_MASTER_ACK_EN
            ST_ACK_SET:   state_nxt = ST_ACK_CLR;
            ST_ACK_CLR:   state_nxt = ST_POLL_ADDR;
`endif
            ST_POLL_ADDR: state_nxt = ST_POLL_WAIT;
            // Keep re-polling until the port reads back zero; no timeout.
            ST_POLL_WAIT: state_nxt = poll_clear ? ST_UNMASK : ST_POLL_ADDR;
            ST_UNMASK:    state_nxt = ST_IDLE;
            default:      state_nxt = ST_INIT;
        endcase
    end

    //--------------------------------------------------------------------
    // Bus decode: each write state is visited for exactly one cycle, so
    // every write strobe is a single-cycle pulse.
    //--------------------------------------------------------------------
    always_comb begin
        bus_addr = ADDR_DATA;
        bus_cs   = 1'b0;
        bus_wn   = 1'b1;
        bus_wd   = 32'd0;
        case (state)
            ST_INIT, ST_UNMASK: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_MASK;
                bus_wd   = 32'd1;
            end
            ST_MASK_OFF: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_MASK;
                bus_wd   = 32'd0;
            end
            ST_RD_ADDR, ST_POLL_ADDR: begin
                bus_cs   = 1'b1;
                bus_addr = ADDR_DATA;
            end
`ifdef PIO_IRQ_MASTER_ACK_EN
            ST_ACK_SET: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_DATA;
                bus_wd   = 32'd1;
            end
            ST_ACK_CLR: begin
                bus_cs   = 1'b1;
                bus_wn   = 1'b0;
                bus_addr = ADDR_DATA;
                bus_wd   = 32'd0;
            end
`endif
            default: begin
                bus_addr = ADDR_DATA;
            end
        endcase
    end

    // INIT is the reset state but must not strobe the slave while reset is
    // held; gating with reset_n keeps the bus idle during reset and lets the
    // unmask write appear in the very first cycle after release.
    assign chipselect = bus_cs & reset_n;
    assign write_n    = bus_wn | ~reset_n;
    assign address    = reset_n ? bus_addr : ADDR_DATA;
    assign writedata  = reset_n ? bus_wd : 32'd0;

    //--------------------------------------------------------------------
    // Event channel
    //--------------------------------------------------------------------
    assign evt_valid = (state == ST_PUSH);

    // Captured on the edge leaving RD_WAIT, when the one-cycle read data is
    // on the bus; it then stays put until the next service.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_data <= '0;
        end else if (state == ST_RD_WAIT) begin
            evt_data <= readdata[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_count <= '0;
        end else if (handshake) begin
            evt_count <= evt_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pio_irq_master.sv
module tb_pio_irq_master;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 5;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
    } evt_t;

    logic              clk;
    logic              reset_n;
    logic              en;
    logic              irq;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic              evt_valid;
    logic              evt_ready;
    logic [DATA_W-1:0] evt_data;
    logic [CNT_W-1:0]  evt_count;

    bus_t        exp_bus_q[$];
    evt_t        exp_evt_q[$];
    logic [31:0] script_q[$];
    int          lat_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_cnt = 0;
    int ready_mode = 0;
    int txn_seen = 0;
    int last_stall = 0;
    int svc_issued = 0;
    int svc_drained = 0;
    logic mask = 1'b0;

    // Slave interrupt: pending source condition gated by the slave's mask register.
    assign irq = mask & (svc_issued != svc_drained);

    pio_irq_master #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .irq        (irq),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_data   (evt_data),
        .evt_count  (evt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // PIO slave model: mask register at address 2, data port reads served
    // from the per-service script one cycle after the request.
    initial begin : slave
        bit          rd;
        bit          wr;
        logic [1:0]  a;
        logic [31:0] wd;
        readdata = '0;
        forever begin
            @(negedge clk);
            rd = reset_n && chipselect && write_n;
            wr = reset_n && chipselect && !write_n;
            a  = address;
            wd = writedata;
            @(posedge clk);
            #1;
            if (!reset_n) mask = 1'b0;
            else if (wr && a == 2'd2) mask = wd[0];
            if (rd && script_q.size() != 0) begin
                readdata = script_q.pop_front();
                if (script_q.size() == 0) svc_drained++;
            end else begin
                readdata = $urandom;
            end
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = stall the first 5 valid cycles.
    initial begin : ready_drv
        int vcnt;
        vcnt = 0;
        evt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0) begin
                evt_ready = 1'b1;
            end else if (ready_mode == 1) begin
                evt_ready = ($urandom_range(0, 1) == 1);
            end else begin
                if (evt_valid) vcnt++;
                else vcnt = 0;
                evt_ready = (vcnt > 5);
            end
        end
    end

    // Scoreboard monitor: pops expected bus transactions and events as the DUT presents them.
    initial begin : monitor
        bit                prev_vld;
        bit                prev_rdy;
        logic [DATA_W-1:0] prev_dat;
        bit                cnt_chk;
        logic [CNT_W-1:0]  cnt_exp;
        int                cur_k;
        int                stall;
        int                k;
        bus_t              b;
        evt_t              e;
        prev_vld = 0; prev_rdy = 0; prev_dat = '0;
        cnt_chk = 0; cnt_exp = '0; cur_k = -1; stall = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_vld = 0; prev_rdy = 0; cnt_chk = 0; cur_k = -1; stall = 0;
                continue;
            end
            if (cnt_chk) begin
                chk("count_incr", evt_count, cnt_exp);
                cnt_chk = 0;
            end
            if (chipselect) begin
                txn_seen++;
                if (exp_bus_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bus: wr=%0b addr=%0d wdata=0x%0h, nothing expected (cycle %0d)",
                             !write_n, address, writedata, cyc);
                end else begin
                    b = exp_bus_q.pop_front();
                    chk("bus_dir", !write_n, b.wr);
                    chk("bus_addr", address, b.addr);
                    if (b.wr) chk("bus_wdata", writedata, b.wdata);
                    if (b.wr && b.addr == 2'd2 && b.wdata == 32'd0 && lat_q.size() != 0) begin
                        k = lat_q.pop_front();
                        chk("mask_off_edge", cyc + 1, k + 1);
                        cur_k = k;
                    end
                end
            end else begin
                chk("bus_idle", {29'b0, write_n, address, writedata}, {29'b0, 1'b1, 34'b0});
            end
            if (prev_vld && !prev_rdy) begin
                chk("hold_valid", evt_valid, 1'b1);
                chk("hold_data", evt_data, prev_dat);
            end
            if (evt_valid) begin
                if (!prev_vld && cur_k >= 0) begin
                    chk("valid_edge", cyc + 1, cur_k + 4);
                    cur_k = -1;
                end
                if (evt_ready) begin
                    if (exp_evt_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event: data=0x%0h count=%0d, nothing expected", evt_data, evt_count);
                    end else begin
                        e = exp_evt_q.pop_front();
                        chk("evt_data", evt_data, e.data);
                        chk("evt_count_pre", evt_count, e.cnt);
                        cnt_exp = CNT_W'((int'(e.cnt) + 1) % (1 << CNT_W));
                        cnt_chk = 1;
                    end
                    last_stall = stall;
                    stall = 0;
                end else begin
                    stall++;
                end
            end
            prev_vld = evt_valid;
            prev_rdy = evt_ready;
            prev_dat = evt_data;
        end
    end

    // One interrupt service: d is the first data read, npoll non-zero polls precede the clearing poll.
    task automatic issue(input logic [31:0] d, input int npoll, input bit now);
        evt_t        e;
        logic [31:0] v;
        script_q.push_back(d);
        for (int i = 0; i < npoll; i++) begin
            v = $urandom;
            if (v[DATA_W-1:0] == '0) v[0] = 1'b1;
            script_q.push_back(v);
        end
        v = $urandom;
        v[DATA_W-1:0] = '0;
        script_q.push_back(v);
        exp_bus_q.push_back('{1'b1, 2'd2, 32'd0});
        exp_bus_q.push_back('{1'b0, 2'd0, 32'd0});
`ifdef PIO_IRQ_MASTER_ACK_EN
        exp_bus_q.push_back('{1'b1, 2'd0, 32'd1});
        exp_bus_q.push_back('{1'b1, 2'd0, 32'd0});
`endif
        for (int i = 0; i <= npoll; i++) exp_bus_q.push_back('{1'b0, 2'd0, 32'd0});
        exp_bus_q.push_back('{1'b1, 2'd2, 32'd1});
        e.data = d[DATA_W-1:0];
        e.cnt  = CNT_W'(model_cnt);
        exp_evt_q.push_back(e);
        model_cnt = (model_cnt + 1) % (1 << CNT_W);
        if (now) lat_q.push_back(cyc + 1);
        svc_issued++;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_bus_q.size() != 0 || exp_evt_q.size() != 0) && n < 400) begin
            step();
            n++;
        end
        chk("service_done", exp_bus_q.size() + exp_evt_q.size(), 0);
        if (n >= 400) begin
            exp_bus_q.delete();
            exp_evt_q.delete();
        end
        repeat (2) step();
    endtask

    task automatic release_reset();
        exp_bus_q.push_back('{1'b1, 2'd2, 32'd1});
        reset_n = 1'b1;
        @(negedge clk);
        chk("init_write", {28'b0, chipselect, write_n, address, writedata}, {28'b0, 1'b1, 1'b0, 2'd2, 32'd1});
        @(negedge clk);
        chk("after_init_idle", {28'b0, chipselect, write_n, address, writedata}, {28'b0, 1'b0, 1'b1, 2'd0, 32'd0});
        step();
    endtask

    initial begin : stim
        int  n0;
        bit  found;
        reset_n = 1'b0;
        en = 1'b0;
        repeat (3) step();
        chk("rst_bus", {28'b0, chipselect, write_n, address, writedata}, {28'b0, 1'b0, 1'b1, 34'b0});
        chk("rst_evt", {evt_valid, evt_data, evt_count}, 0);
        release_reset();

        // First event: data 1, immediate accept, count 1.
        en = 1'b1;
        step();
        issue(32'h1, 0, 1);
        wait_done();
        chk("count_first", evt_count, 1);

        // Three non-zero polls before the port clears.
        issue($urandom, 3, 1);
        wait_done();

        // Consumer stalls five cycles.
        ready_mode = 2;
        issue($urandom, 1, 1);
        wait_done();
        chk("stall_len", last_stall, 5);
        ready_mode = 0;

        // en dropped mid-service: the service still completes.
        issue($urandom, 2, 1);
        repeat (2) step();
        en = 1'b0;
        wait_done();

        // irq with en low is ignored until en returns.
        issue($urandom, 0, 0);
        n0 = txn_seen;
        repeat (10) step();
        chk("en_gate", txn_seen, n0);
        en = 1'b1;
        lat_q.push_back(cyc + 1);
        wait_done();

        // Randomized services; enough of them to wrap the counter.
        for (int i = 0; i < 36; i++) begin
            ready_mode = $urandom_range(0, 1);
            issue($urandom, $urandom_range(0, 3), 1);
            wait_done();
        end
        ready_mode = 0;
        chk("count_model", evt_count, model_cnt);

        // Reset while waiting for the data read to return.
        issue($urandom, 1, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (chipselect && write_n) found = 1;
        end
        chk("rd_seen", found, 1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_bus", {28'b0, chipselect, write_n, address, writedata}, {28'b0, 1'b0, 1'b1, 34'b0});
        chk("midrst_evt", {evt_valid, evt_data, evt_count}, 0);
        exp_bus_q.delete();
        exp_evt_q.delete();
        lat_q.delete();
        script_q.delete();
        svc_issued = svc_drained;
        model_cnt = 0;
        repeat (2) step();
        release_reset();

        issue(32'h5, 0, 1);
        wait_done();
        chk("count_after_reset", evt_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
